// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient pipeline.
package sobel_pkg;

    localparam int GRAD_W = 8;

    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [GRAD_W-1:0] mag_t;

    // Clamp any magnitude up to 2*GRAD_W+1 bits into the output range.
    function automatic mag_t sat_mag(input logic [2*GRAD_W:0] value);
        return (value > (2*GRAD_W+1)'({GRAD_W{1'b1}})) ? '1 : value[GRAD_W-1:0];
    endfunction

endpackage

// File: rtl/total_gradient_if.sv
// Streaming gradient bus: gx/gy/threshold in, magnitude/edge flag out.
interface total_gradient_if
    import sobel_pkg::*;
#(
    parameter int WIDTH = GRAD_W
);
    logic             in_valid;
    logic [WIDTH-1:0] gx;
    logic [WIDTH-1:0] gy;
    logic [WIDTH-1:0] threshold;
    logic [WIDTH-1:0] g;
    // "edge" is a reserved word, so the flag is carried as is_edge.
    logic             is_edge;
    logic             out_valid;

    modport master (
        output in_valid, gx, gy, threshold,
        input  g, is_edge, out_valid
    );

    modport slave (
        input  in_valid, gx, gy, threshold,
        output g, is_edge, out_valid
    );
endinterface

// File: rtl/total_gradient_isqrt.sv
// Combinational unrolled restoring integer square root; built only when
// TOTAL_GRADIENT_SQRT_EN is defined.
`ifdef TOTAL_GRADIENT_SQRT_EN
module isqrt #(
    parameter int IN_W  = 17,
    parameter int OUT_W = (IN_W + 1) / 2
) (
    input  logic [IN_W-1:0]  radicand,
    output logic [OUT_W-1:0] root
);
    logic [2*OUT_W-1:0] rad;
    logic [OUT_W+1:0]   rem;
    logic [OUT_W+1:0]   trial;
    logic [OUT_W-1:0]   acc;

    assign rad = (2*OUT_W)'(radicand);

    // Remainder never exceeds 2*acc, so its top two bits are free before each shift.
    always_comb begin
        rem   = '0;
        acc   = '0;
        trial = '0;
        for (int unsigned i = OUT_W; i >= 1; i--) begin
            rem   = {rem[OUT_W-1:0], rad[2*i-1 -: 2]};
            trial = {acc, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                acc = (acc << 1) | OUT_W'(1);
            end else begin
                acc = acc << 1;
            end
        end
        root = acc;
    end
endmodule
`endif

// File: rtl/total_gradient.sv
// Two-stage gradient magnitude: |gx|+|gy| saturated (default) or
// floor(sqrt(gx^2+gy^2)) saturated when TOTAL_GRADIENT_SQRT_EN is defined.
module total_gradient
    import sobel_pkg::*;
#(
    parameter int WIDTH = GRAD_W
) (
    input logic             clk,
    input logic             rst,
    total_gradient_if.slave bus
);
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(~v + 1'b1) : v;
    endfunction

    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] ay;
    logic [WIDTH-1:0] thr_s1;
    logic             valid_s1;
    logic [WIDTH:0]   mag;
    logic [WIDTH-1:0] g_next;
    logic [WIDTH-1:0] g_q;
    logic             edge_q;
    logic             valid_q;

    assign ax = abs_val(bus.gx);
    assign ay = abs_val(bus.gy);

`ifdef TOTAL_GRADIENT_SQRT_EN
    logic [2*WIDTH:0] sq_next;
    logic [2*WIDTH:0] sq_s1;

    assign sq_next = (2*WIDTH+1)'(ax) * (2*WIDTH+1)'(ax)
                   + (2*WIDTH+1)'(ay) * (2*WIDTH+1)'(ay);

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_s1 <= '0;
        end else begin
            sq_s1 <= sq_next;
        end
    end

    isqrt #(
        .IN_W  (2*WIDTH+1),
        .OUT_W (WIDTH+1)
    ) u_isqrt (
        .radicand (sq_s1),
        .root     (mag)
    );
`else
    logic [WIDTH-1:0] ax_s1;
    logic [WIDTH-1:0] ay_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ax_s1 <= '0;
            ay_s1 <= '0;
        end else begin
            ax_s1 <= ax;
            ay_s1 <= ay;
        end
    end

    assign mag = {1'b0, ax_s1} + {1'b0, ay_s1};
`endif

    assign g_next = mag[WIDTH] ? '1 : mag[WIDTH-1:0];

    // Data registers load every cycle; only valid and the edge flag are qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_s1   <= '0;
            valid_s1 <= 1'b0;
            g_q      <= '0;
            edge_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            thr_s1   <= bus.threshold;
            valid_s1 <= bus.in_valid;
            g_q      <= g_next;
            edge_q   <= valid_s1 && (g_next >= thr_s1);
            valid_q  <= valid_s1;
        end
    end

    assign bus.g         = g_q;
    assign bus.is_edge   = edge_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_total_gradient.sv
// Self-checking bench for total_gradient: directed table, hand sequences, random stream.
module tb_total_gradient;
    localparam int W     = 8;
    localparam int G_MAX = (1 << W) - 1;
`ifdef TOTAL_GRADIENT_SQRT_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic clk;
    logic rst;

    total_gradient_if #(.WIDTH(W)) bus ();

    total_gradient #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit valid;
        bit known;
        int g;
        bit edg;
    } exp_t;

    typedef struct {
        bit v;
        int x;
        int y;
        int thr;
        int g;
        bit e;
    } vec_t;

    exp_t s1;
    exp_t s2;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[13];

    function automatic int ref_mag(int x, int y);
        int m;
        if (SQ) begin
            int s;
            s = x * x + y * y;
            m = 0;
            while ((m + 1) * (m + 1) <= s) m++;
        end else begin
            m = (x < 0 ? -x : x) + (y < 0 ? -y : y);
        end
        return (m > G_MAX) ? G_MAX : m;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs, advance the reference pipeline, compare outputs.
    task automatic step(input bit r, input bit v, input int x, input int y,
                        input int thr, input string tag);
        int m;
        rst           = r;
        bus.in_valid  = v;
        bus.gx        = W'(x);
        bus.gy        = W'(y);
        bus.threshold = W'(thr);
        @(posedge clk);
        #1;
        if (r) begin
            s2 = '{valid: 1'b0, known: 1'b1, g: 0, edg: 1'b0};
            s1 = '{valid: 1'b0, known: 1'b1, g: 0, edg: 1'b0};
        end else begin
            s2 = s1;
            if (v) begin
                m  = ref_mag(x, y);
                s1 = '{valid: 1'b1, known: 1'b1, g: m, edg: (m >= thr)};
            end else begin
                s1 = '{valid: 1'b0, known: 1'b0, g: 0, edg: 1'b0};
            end
        end
        check($sformatf("%s.out_valid", tag), int'(bus.out_valid), int'(s2.valid));
        if (s2.valid || s2.known) begin
            check($sformatf("%s.g", tag), int'(bus.g), s2.g);
            check($sformatf("%s.edge", tag), int'(bus.is_edge), int'(s2.edg));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1,    0,    0,   0, 0,                 1'b1};
        tbl[1]  = '{1'b1,    3,   -4,   8, SQ ? 5 : 7,        1'b0};
        tbl[2]  = '{1'b1, -128, -128,   0, SQ ? 181 : 255,    1'b1};
        tbl[3]  = '{1'b1,   10,    0,   0, 10,                1'b1};
        tbl[4]  = '{1'b1,   20,    0,  15, 20,                1'b1};
        tbl[5]  = '{1'b1,   30,    0,  31, 30,                1'b0};
        tbl[6]  = '{1'b0,   77,   -9,   3, 0,                 1'b0};
        tbl[7]  = '{1'b1,    5,   -5,  10, SQ ? 7 : 10,       SQ ? 1'b0 : 1'b1};
        tbl[8]  = '{1'b0,  -50,   60,   0, 0,                 1'b0};
        tbl[9]  = '{1'b1,  127,  127, 255, SQ ? 179 : 254,    1'b0};
        tbl[10] = '{1'b1,   -1,    0,   1, 1,                 1'b1};
        tbl[11] = '{1'b1,  100, -100, 200, SQ ? 141 : 200,    SQ ? 1'b0 : 1'b1};
        tbl[12] = '{1'b1, -128,  127, 255, 255,               1'b1};
        if (SQ) tbl[12].g = 180;
        if (SQ) tbl[12].e = 1'b0;

        s1 = '{valid: 1'b0, known: 1'b0, g: 0, edg: 1'b0};
        s2 = s1;

        // Reset held for two cycles: outputs cleared.
        step(1'b1, 1'b0, 0, 0, 0, "rst0");
        step(1'b1, 1'b0, 0, 0, 0, "rst1");

        // Directed table, back-to-back; vector i-1 emerges after step i.
        for (int i = 0; i <= 13; i++) begin
            if (i < 13) step(1'b0, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].thr, $sformatf("tbl%0d", i));
            else        step(1'b0, 1'b0, 0, 0, 0, "tbl_drain");
            if (i >= 1) begin
                check($sformatf("vec%0d.out_valid", i - 1), int'(bus.out_valid), int'(tbl[i-1].v));
                if (tbl[i-1].v) begin
                    check($sformatf("vec%0d.g", i - 1), int'(bus.g), tbl[i-1].g);
                    check($sformatf("vec%0d.edge", i - 1), int'(bus.is_edge), int'(tbl[i-1].e));
                end
            end
        end

        // Latency: a lone pixel appears after exactly two edges, not one or three.
        step(1'b0, 1'b1, 9, 0, 0, "lat_in");
        check("lat.edge1_valid", int'(bus.out_valid), 0);
        step(1'b0, 1'b0, 0, 0, 0, "lat_w1");
        check("lat.edge2_valid", int'(bus.out_valid), 1);
        check("lat.edge2_g", int'(bus.g), 9);
        step(1'b0, 1'b0, 0, 0, 0, "lat_w2");
        check("lat.edge3_valid", int'(bus.out_valid), 0);

        // Mid-stream reset with pixels in flight: none of them emerge.
        step(1'b0, 1'b1, 50, 0, 0, "mr_a");
        step(1'b1, 1'b1, 60, 0, 0, "mr_rst");
        check("mr.rst_valid", int'(bus.out_valid), 0);
        check("mr.rst_g", int'(bus.g), 0);
        step(1'b0, 1'b0, 0, 0, 0, "mr_idle1");
        check("mr.idle1_valid", int'(bus.out_valid), 0);
        step(1'b0, 1'b0, 0, 0, 0, "mr_idle2");
        check("mr.idle2_valid", int'(bus.out_valid), 0);

        // Randomised stream against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit r;
            bit v;
            int x;
            int y;
            int thr;
            r   = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 3) != 0);
            x   = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            y   = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            thr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            step(r, v, x, y, thr, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/total_gradient.md
Name: total_gradient

Overview:
- Sobel edge-detection magnitude stage: combines horizontal (gx) and vertical (gy) gradient components into one saturated gradient magnitude g per pixel.
- Sits between the Sobel convolution block (gx/gy producer) and the edge-map writer.
- Streaming, fully pipelined, accepts one pixel per clock, fixed 2-cycle latency, plus a thresholded edge flag.

Parameters:
- WIDTH, 8, bit width of gx, gy, g and threshold.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  gx/gy valid this cycle
- gx  input  WIDTH  horizontal gradient, signed two's complement
- gy  input  WIDTH  vertical gradient, signed two's complement
- threshold  input  WIDTH  unsigned edge threshold, sampled with stage 1
- g  output  WIDTH  unsigned gradient magnitude, registered
- edge  output  1  1 when g >= sampled threshold, registered
- out_valid  output  1  g/edge valid this cycle

Behaviour:
- Single clock domain (clk); reset synchronous and active-high (rst). Already decided.
- Reset: g=0, edge=0, out_valid=0, all pipeline registers (abs values, valid, threshold copy) = 0. rst asserted mid-stream discards in-flight pixels; no output valid until 2 cycles after first post-reset in_valid.
- Stage 1 (cycle N, in_valid=1): register ax=|gx|, ay=|gy| as WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) (e.g. |-128| = 128), no overflow. Register threshold and valid.
- Stage 2 (cycle N+1): sum = ax + ay in WIDTH+1 bits; g = sum saturated to 2^WIDTH-1 (255 for WIDTH=8). edge = (g >= threshold_s1). out_valid = valid_s1.
- Latency: exactly 2 rising edges from in_valid sample to out_valid=1. Throughput 1/cycle, no backpressure.
- in_valid=0: pipeline still advances; valid bits propagate 0; data registers are don't-care but must be deterministic (load regardless of valid is acceptable).
- threshold=0: edge=1 for every valid pixel, including g=0.
- gx=gy=0 -> g=0.

Optional Feature:
- Macro TOTAL_GRADIENT_SQRT_EN.
- Defined: g = floor(sqrt(gx^2 + gy^2)) saturated to 2^WIDTH-1; stage 1 registers ax^2 + ay^2 (2*WIDTH+1 bits); stage 2 computes integer square root combinationally (unrolled restoring algorithm). Latency unchanged at 2.
- Undefined: L1 approximation |gx|+|gy| with saturation as above.

Decomposition:
- Package sobel_pkg: localparam GRAD_W = 8, typedef grad_t (signed GRAD_W), mag_t (unsigned GRAD_W), function sat_mag (saturate WIDTH+1 or wider to mag_t).
- One sub-module natural: isqrt (combinational integer square root, parameterised input width), instantiated only under TOTAL_GRADIENT_SQRT_EN.

Test Plan:
- rst=1 for 2 cycles, then gx=0, gy=0, in_valid=1, threshold=0 -> 2 cycles later g=0, edge=1, out_valid=1; during reset g=0, out_valid=0.
- gx=3, gy=-4, threshold=8 -> g=7 (L1) / 5 (SQRT_EN), edge=0, after exactly 2 cycles.
- gx=-128, gy=-128 -> L1 sum 256 saturates g=255; SQRT_EN g=181.
- Back-to-back stream gx=10,20,30 with gy=0 on consecutive cycles -> g=10,20,30 on consecutive cycles, out_valid held 1.
- in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed 2 cycles.
- rst asserted while 2 pixels in flight -> next cycle out_valid=0, g=0; in-flight pixels never emerge.
